// File: rtl/vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter
//
// Round-robin arbiter that shares the single VGA pixel-write port among up to
// N_REQ sprite drawers. Index 0 is User1, index 1 is User2, and 2..7 are
// bullets. A drawer raises req and waits for its grant bit. It then streams
// pixels, one per cycle at most, and finally releases with done or by
// dropping req. The winning pixel is registered onto the VGA adapter inputs.
// A drawer that never releases is cut off after MAX_BURST accepted pixels.
//
// Ports
//   CLOCK_50     system clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   req          per-requester ownership request (level)
//   done         per-requester release pulse
//   pix_valid    per-requester pixel strobe
//   pix_x/y/color  packed pixel data; requester i at [i*W +: W]
//   grant        one-hot ownership, all-zero when nobody owns the port
//   VGA_X/Y/COLOR  registered pixel to the VGA adapter
//   plot_enable  registered write strobe matching VGA_X/Y/COLOR
//   busy         high while a grant is held
//   timeout_err  one-cycle pulse when a burst is forcibly terminated
// ---------------------------------------------------------------------------
module vga_plot_arbiter #(
  parameter int N_REQ     = 8,
  parameter int MAX_BURST = 256,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int C_W       = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  input  logic [N_REQ-1:0]     pix_valid,
  input  logic [N_REQ*X_W-1:0] pix_x,
  input  logic [N_REQ*Y_W-1:0] pix_y,
  input  logic [N_REQ*C_W-1:0] pix_color,
  output logic [N_REQ-1:0]     grant,
  output logic [X_W-1:0]       VGA_X,
  output logic [Y_W-1:0]       VGA_Y,
  output logic [C_W-1:0]       VGA_COLOR,
  output logic                 plot_enable,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_REQ - 1);

  // Architectural state
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             busy_q, busy_d;

  // Registered VGA-side outputs
  logic [X_W-1:0]   vga_x_q, vga_x_d;
  logic [Y_W-1:0]   vga_y_q, vga_y_d;
  logic [C_W-1:0]   vga_color_q, vga_color_d;
  logic             plot_enable_q, plot_enable_d;
  logic             timeout_err_q, timeout_err_d;

  // Round-robin scan result
  logic             scan_found;
  logic [PTR_W-1:0] scan_idx;

  // Current owner's view of the request bus
  logic             own_req;
  logic             own_done;
  logic             own_valid;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [C_W-1:0]   own_color;

  // Release decision for the OWN state
  logic             limit_hit;
  logic             release_now;

  // Round-robin scan: first asserted req at or above ptr, wrapping around.
  // The candidate index is reduced modulo N_REQ so non-power-of-two counts
  // also wrap correctly.
  always_comb begin
    logic [PTR_W-1:0] cand;
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!scan_found && req[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  // Multiplex the owner's lane out of the packed buses. Non-owner lanes are
  // never looked at, which is what isolates other drawers' pixels and dones.
  always_comb begin
    own_req   = 1'b0;
    own_done  = 1'b0;
    own_valid = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        own_req   = req[i];
        own_done  = done[i];
        own_valid = pix_valid[i];
        own_x     = pix_x[i*X_W +: X_W];
        own_y     = pix_y[i*Y_W +: Y_W];
        own_color = pix_color[i*C_W +: C_W];
      end
    end
  end

  // The burst limit is reached by the pixel that brings the count to
  // MAX_BURST. The counter never exceeds MAX_BURST-1 while in OWN, so the
  // increment here cannot overflow.
  always_comb begin
    limit_hit   = own_valid && ((burst_cnt_q + CNT_W'(1)) == BURST_LIMIT);
    release_now = own_done || !own_req || limit_hit;
  end

  // Next-state logic for the IDLE -> OWN -> GAP -> IDLE cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    burst_cnt_d   = burst_cnt_q;
    busy_d        = busy_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_color_d   = vga_color_q;
    plot_enable_d = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          state_d     = ST_OWN;
          owner_d     = scan_idx;
          burst_cnt_d = '0;
          busy_d      = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            grant_d[i] = (scan_idx == PTR_W'(i));
          end
        end
      end

      ST_OWN: begin
        // The pixel on the release cycle is still plotted.
        if (own_valid) begin
          vga_x_d       = own_x;
          vga_y_d       = own_y;
          vga_color_d   = own_color;
          plot_enable_d = 1'b1;
          if (burst_cnt_q != BURST_LIMIT) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end

        if (release_now) begin
          state_d = ST_GAP;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
          // Only a pure burst-limit cut-off counts as an error; a polite
          // release that happens to coincide with the limit does not.
          timeout_err_d = limit_hit && !own_done && own_req;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset. A reset mid-burst simply drops
  // the grant; no error pulse is produced and arbitration restarts at 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      burst_cnt_q   <= '0;
      busy_q        <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_color_q   <= '0;
      plot_enable_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      burst_cnt_q   <= burst_cnt_d;
      busy_q        <= busy_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_color_q   <= vga_color_d;
      plot_enable_q <= plot_enable_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign VGA_X       = vga_x_q;
  assign VGA_Y       = vga_y_q;
  assign VGA_COLOR   = vga_color_q;
  assign plot_enable = plot_enable_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Round-robin arbiter that shares the single VGA pixel-write port among up to eight sprite drawers: two players and six bullets. Each drawer requests ownership, streams its pixels while granted, then releases. The arbiter registers the winning stream onto the VGA adapter inputs. It replaces fixed time-slicing: idle drawers consume no slots, and a runaway drawer is cut off after a bounded burst.

## Interface
- N_REQ, 8, number of requesters (index 0 = User1, 1 = User2, 2..7 = bullets)
- MAX_BURST, 256, max pixels accepted per grant before forced release
- X_W, 9, pixel X width
- Y_W, 8, pixel Y width
- C_W, 3, colour width
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester ownership request (level)
- done  in  N_REQ  per-requester release pulse
- pix_valid  in  N_REQ  per-requester pixel strobe
- pix_x  in  N_REQ*X_W  packed X, requester i at [i*X_W +: X_W]
- pix_y  in  N_REQ*Y_W  packed Y
- pix_color  in  N_REQ*C_W  packed colour
- grant  out  N_REQ  one-hot ownership (all-zero when unowned)
- VGA_X  out  X_W  registered pixel X to VGA adapter
- VGA_Y  out  Y_W  registered pixel Y
- VGA_COLOR  out  C_W  registered colour
- plot_enable  out  1  registered write strobe
- busy  out  1  high when a grant is held
- timeout_err  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, OWN, GAP.
- **IDLE:**
  - If req is non-zero, pick the first asserted req scanning upward from ptr, with wrap-around.
  - Load owner, set grant[owner], clear burst_cnt, go to OWN.
- **OWN:**
  - Each cycle with pix_valid[owner] = 1, register that requester's x/y/colour to the VGA outputs and set plot_enable = 1. Otherwise plot_enable = 0.
  - Each accepted pixel increments burst_cnt. burst_cnt is $clog2(MAX_BURST+1) bits and saturates; it never wraps.
  - Release conditions, evaluated each OWN cycle:
    - done[owner] = 1.
    - req[owner] = 0.
    - burst_cnt reaches MAX_BURST on this cycle's accepted pixel.
  - On release: go to GAP and set ptr = (owner+1) mod N_REQ.
  - A pixel presented on the release cycle is still accepted.
  - timeout_err pulses only for the burst-limit release, and only when neither done[owner] nor a req drop occurs in the same cycle.
- **GAP:** grant = 0 and busy = 0 for one cycle, then IDLE. This guarantees one idle cycle between owners.
- pix_valid and done from non-owners are ignored in every state. Nothing is buffered.
- plot_enable is 0 in IDLE and GAP, except for the single registered pixel that was accepted on the release cycle.
- Reset values:
  - state = IDLE, ptr = 0, grant = 0, busy = 0, plot_enable = 0, timeout_err = 0.
  - VGA_X, VGA_Y and VGA_COLOR = 0.
  - burst_cnt = 0.
- Reset mid-OWN aborts the burst with no error pulse; the next arbitration starts from ptr = 0.

## Timing
- req sampled high in IDLE at edge t: grant and busy high after edge t (one-cycle arbitration latency).
- pix_valid[owner] at edge t: VGA_X/Y/COLOR and plot_enable valid after edge t, held one cycle.
- Release condition at edge t: state = GAP after edge t, so grant and busy are low from that edge on. timeout_err is high for the cycle following edge t.
- Earliest next grant is after edge t+2. Owner-to-owner turnaround is 2 idle cycles.
- Peak throughput is 1 pixel/cycle within a grant.
- Requester obligations:
  - Hold req until it observes grant.
  - Drive pixels only while grant[i] = 1.
  - Pulse done for one cycle, with or after the last pixel.

## Test plan
- **Single requester:** req[0] held, pixels (10,20,001), (11,20,001), (12,20,001) on consecutive cycles, done with the third. Required: grant = 8'b0000_0001 one cycle after req; three consecutive plot_enable pulses with matching coordinates; grant drops after done; timeout_err stays 0.
- **Round-robin fairness:** req[0] and req[5] held continuously, each doing 1-pixel bursts with done. Required: grant alternates 0, 5, 0, 5 with two idle cycles between grants.
- **Burst limit:** MAX_BURST = 4, requester 2 streams 6 pixels without done. Required: exactly 4 plot_enable pulses, timeout_err pulses once, ptr advances to 3.
- **Isolation:** requester 3 drives pix_valid with (150,160,101) while requester 1 owns. Required: no plot_enable carries requester 3's data.
- **Done on the limit pixel:** done asserted together with the MAX_BURST-th pixel. Required: that pixel is plotted and timeout_err = 0.
- **Reset mid-burst:** reset asserted for 1 cycle during requester 4's OWN. Required: all outputs 0 on the next cycle; with req[4] and req[6] held, next grant goes to 4 (scan from ptr 0).
